// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// ID resolves branches/jumps and steers pc_src; a taken redirect costs one flushed IF/ID slot.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic        inst_clear,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'b00,
        SRC_BRANCH = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_RSVD   = 2'b11
    } pc_src_e;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    // Jump region comes from the instruction sitting in ID, not from the current PC.
    assign jump_target = {ifid_pc4[31:28], ifid_inst[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src_e'(pc_src))
            SRC_BRANCH: next_pc = branch_target;
            SRC_JUMP:   next_pc = jump_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            ifid_inst   <= '0;
            ifid_pc4    <= '0;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else if (!stall) begin
            pc <= next_pc;
            if (inst_clear) begin
                ifid_inst  <= '0;
                ifid_pc4   <= '0;
                ifid_valid <= 1'b0;
            end else begin
                ifid_inst   <= imem_rdata;
                ifid_pc4    <= pc_plus4;
                ifid_valid  <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors plus reset corner sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic        inst_clear;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_src        (pc_src),
        .inst_clear    (inst_clear),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_inst     (ifid_inst),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: a few fixed words, everything else is 0xC0000000 | address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0003;
            32'h0000_0008: return 32'h0800_0020;
            32'h7000_0000: return 32'h0800_0010;
            default:       return 32'hC000_0000 | a;
        endcase
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    typedef struct {
        logic        stall;
        logic [1:0]  src;
        logic        clr;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[21];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                               input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
        check32({tag, " imem_addr"},   imem_addr,        pc);
        check32({tag, " ifid_inst"},   ifid_inst,        inst);
        check32({tag, " ifid_pc4"},    ifid_pc4,         pc4);
        check32({tag, " ifid_valid"},  {31'd0, ifid_valid}, {31'd0, valid});
        check32({tag, " fetch_count"}, fetch_count,      cnt);
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] src, input logic c,
                         input logic [31:0] t);
        rst = r; stall = s; pc_src = src; inst_clear = c; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          stall src    clr  target          pc              inst            pc4             v     cnt
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0,         32'h4,          32'h2008_0005,  32'h4,          1'b1, 32'd1};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0,         32'h8,          32'h2009_0003,  32'h8,          1'b1, 32'd2};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0,         32'hC,          32'h0800_0020,  32'hC,          1'b1, 32'd3};
        vecs[3]  = '{1'b0, 2'b10, 1'b1, 32'h0,         32'h80,         32'h0,          32'h0,          1'b0, 32'd3};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0,         32'h84,         32'hC000_0080,  32'h84,         1'b1, 32'd4};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h10,        32'h10,         32'h0,          32'h0,          1'b0, 32'd4};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h40,        32'h40,         32'h0,          32'h0,          1'b0, 32'd4};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h0,         32'h44,         32'hC000_0040,  32'h44,         1'b1, 32'd5};
        vecs[8]  = '{1'b1, 2'b01, 1'b1, 32'h200,       32'h44,         32'hC000_0040,  32'h44,         1'b1, 32'd5};
        vecs[9]  = '{1'b1, 2'b01, 1'b1, 32'h200,       32'h44,         32'hC000_0040,  32'h44,         1'b1, 32'd5};
        vecs[10] = '{1'b1, 2'b01, 1'b1, 32'h200,       32'h44,         32'hC000_0040,  32'h44,         1'b1, 32'd5};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h200,       32'h200,        32'h0,          32'h0,          1'b0, 32'd5};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h999,       32'h204,        32'hC000_0200,  32'h204,        1'b1, 32'd6};
        vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h300,       32'h300,        32'hC000_0204,  32'h208,        1'b1, 32'd7};
        vecs[14] = '{1'b0, 2'b01, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC,  32'h0,          32'h0,          1'b0, 32'd7};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 32'h0,         32'h0,          32'hFFFF_FFFC,  32'h0,          1'b1, 32'd8};
        vecs[16] = '{1'b0, 2'b01, 1'b1, 32'h7000_0000, 32'h7000_0000,  32'h0,          32'h0,          1'b0, 32'd8};
        vecs[17] = '{1'b0, 2'b00, 1'b0, 32'h0,         32'h7000_0004,  32'h0800_0010,  32'h7000_0004,  1'b1, 32'd9};
        vecs[18] = '{1'b0, 2'b10, 1'b1, 32'h0,         32'h7000_0040,  32'h0,          32'h0,          1'b0, 32'd9};
        vecs[19] = '{1'b0, 2'b00, 1'b1, 32'h0,         32'h7000_0044,  32'h0,          32'h0,          1'b0, 32'd9};
        vecs[20] = '{1'b0, 2'b00, 1'b0, 32'h0,         32'h7000_0048,  32'hF000_0044,  32'h7000_0048,  1'b1, 32'd10};

        rst = 1'b1; stall = 1'b0; pc_src = 2'b00; inst_clear = 1'b0; branch_target = '0;
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        for (int unsigned i = 0; i < 21; i++) begin
            drive(1'b0, vecs[i].stall, vecs[i].src, vecs[i].clr, vecs[i].tgt);
            check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst, vecs[i].pc4,
                        vecs[i].valid, vecs[i].cnt);
        end

        // Reset during a stall with a redirect pending: everything clears, redirect lost.
        drive(1'b1, 1'b1, 2'b01, 1'b1, 32'h500);
        check_state("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        check_state("post_rst", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 32'd1);

        // Reset during an unstalled redirect also wins.
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h600);
        check_state("rst_redir", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        check_state("stall_after_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        check_state("fetch_after_rst", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
